// File: rtl/kpg_pkg.sv
// kpg_pkg
// Shared types and helpers for the KPG (kill/propagate/generate) prefix adder.
// A KPG code summarises what a group of bit positions does to an incoming
// carry: kill it (K), pass it through (P) or create one (G). Bit 1 of a
// resolved code is the carry itself.
package kpg_pkg;

  typedef logic [1:0] kpg_t;

  localparam kpg_t KPG_K = 2'b00;
  localparam kpg_t KPG_P = 2'b01;
  localparam kpg_t KPG_G = 2'b11;

  // Combine an upper group with the group directly below it: the upper group
  // only defers to the lower one when it merely propagates.
  function automatic kpg_t kpg_merge_f(input kpg_t hi, input kpg_t lo);
    return (hi == KPG_P) ? lo : hi;
  endfunction

  // Code of a single bit position from its two operand bits.
  function automatic kpg_t kpg_of(input logic a_bit, input logic b_bit);
    kpg_t code;
    if (a_bit && b_bit) begin
      code = KPG_G;
    end else if (!a_bit && !b_bit) begin
      code = KPG_K;
    end else begin
      code = KPG_P;
    end
    return code;
  endfunction

endpackage

// File: rtl/kpg_merge_cell.sv
// kpg_merge_cell
// Combinational merge of two KPG codes; one instance per prefix node.
// Ports:
//   hi     - code of the upper (more significant) group
//   lo     - code of the group immediately below it
//   merged - code of the combined group
module kpg_merge_cell
  import kpg_pkg::*;
(
  input  logic [1:0] hi,
  input  logic [1:0] lo,
  output logic [1:0] merged
);

  assign merged = kpg_merge_f(hi, lo);

endmodule

// File: rtl/kpg_prefix_adder_pl.sv
// kpg_prefix_adder_pl
// Fully pipelined Kogge-Stone adder/subtractor built on KPG codes.
// One register stage captures the operands, one stage per prefix level,
// and an output stage forms sum and flags. A single enable advances the
// whole pipe whenever the output register is empty or being drained.
// Ports:
//   clk, rst             - clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  - operand handshake
//   a, b, cin, op        - operands, carry-in (add only), 0=add 1=sub
//   out_valid / out_ready- result handshake
//   sum, cout, ovf, zero - result, carry-out (sub: 1 = no borrow),
//                          signed overflow, result-is-zero
module kpg_prefix_adder_pl
  import kpg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = $clog2(WIDTH);

  // Pipeline state. Index 0 is the operand register, index k holds the
  // codes after prefix level k. Position 0 carries the carry-in, position
  // i+1 describes operand bit i.
  kpg_t             code_q  [0:LEVELS][0:WIDTH];
  logic [WIDTH-1:0] p_q     [0:LEVELS];
  logic [LEVELS:0]  valid_q;
  logic [LEVELS:0]  sa_q;
  logic [LEVELS:0]  sb_q;

  kpg_t             code_d  [0:WIDTH];
  kpg_t             merged  [1:LEVELS][0:WIDTH];
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is a + ~b + 1, so the forced carry-in replaces cin.
  assign b_eff = op ? ~b : b;
  assign c0    = op | cin;

  always_comb begin
    code_d[0] = c0 ? KPG_G : KPG_K;
    for (int i = 0; i < WIDTH; i++) begin
      code_d[i+1] = kpg_of(a[i], b_eff[i]);
    end
  end

  // Prefix network: level k reaches 2^(k-1) positions down; positions too
  // low to have a partner at that distance are already fully resolved.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    for (genvar j = 0; j <= WIDTH; j++) begin : g_pos
      if (j >= (1 << (k - 1))) begin : g_merge
        kpg_merge_cell u_cell (
          .hi    (code_q[k-1][j]),
          .lo    (code_q[k-1][j-(1<<(k-1))]),
          .merged(merged[k][j])
        );
      end else begin : g_pass
        assign merged[k][j] = code_q[k-1][j];
      end
    end
  end

  // Operand and prefix stages. Bubbles travel through like real items; the
  // operand register only loads data when something is actually accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      for (int k = 0; k <= LEVELS; k++) begin
        p_q[k] <= '0;
        for (int j = 0; j <= WIDTH; j++) begin
          code_q[k][j] <= KPG_K;
        end
      end
    end else if (adv) begin
      valid_q[0] <= in_valid;
      if (in_valid) begin
        p_q[0]  <= a ^ b_eff;
        sa_q[0] <= a[WIDTH-1];
        sb_q[0] <= b_eff[WIDTH-1];
        for (int j = 0; j <= WIDTH; j++) begin
          code_q[0][j] <= code_d[j];
        end
      end
      for (int k = 1; k <= LEVELS; k++) begin
        valid_q[k] <= valid_q[k-1];
        p_q[k]     <= p_q[k-1];
        sa_q[k]    <= sa_q[k-1];
        sb_q[k]    <= sb_q[k-1];
        for (int j = 0; j <= WIDTH; j++) begin
          code_q[k][j] <= merged[k][j];
        end
      end
    end
  end

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  kpg_t             top_code;

  // After LEVELS levels each position spans 2^LEVELS = WIDTH positions, so
  // positions 0..WIDTH-1 reach position 0 but the carry-out position stops
  // one short. One last merge with position 0 closes that gap.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      carry[i] = code_q[LEVELS][i][1];
    end
    sum_d    = p_q[LEVELS] ^ carry;
    top_code = kpg_merge_f(code_q[LEVELS][WIDTH], code_q[LEVELS][0]);
  end

  // Output register keeps the last result while a bubble passes, so only a
  // real item changes the visible data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      out_valid <= valid_q[LEVELS];
      if (valid_q[LEVELS]) begin
        sum  <= sum_d;
        cout <= top_code[1];
        ovf  <= (sa_q[LEVELS] == sb_q[LEVELS]) && (sum_d[WIDTH-1] != sa_q[LEVELS]);
        zero <= ~|sum_d;
      end
    end
  end

endmodule
